// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;

    // Credit is counted in 5Rs units.
    localparam int CREDIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } vend_state_e;

    localparam logic [1:0] COIN_INV = 2'b00;
    localparam logic [1:0] COIN_5   = 2'b01;
    localparam logic [1:0] COIN_10  = 2'b10;
    localparam logic [1:0] COIN_20  = 2'b11;

    // Coin code to value in 5Rs units. The result is one bit wider than
    // credit so that a sum can be checked for overflow. An invalid code gives 0.
    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return (CREDIT_W+1)'(1);
            COIN_10: return (CREDIT_W+1)'(2);
            COIN_20: return (CREDIT_W+1)'(4);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// Coin, selection, motor and change-ejector signals of the vending controller.
interface vend_if;
    import vend_pkg::*;

    logic                coin_valid;
    logic [1:0]          coin;
    logic                sel_valid;
    logic [1:0]          sel;
    logic                cancel;
    logic                disp_req;
    logic [1:0]          disp_id;
    logic                disp_ack;
    logic                chg_req;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_rej;
    logic                sel_err;

    modport slave (
        input  coin_valid, coin, sel_valid, sel, cancel, disp_ack, chg_ack,
        output disp_req, disp_id, chg_req, credit, busy, coin_rej, sel_err
    );

    modport master (
        output coin_valid, coin, sel_valid, sel, cancel, disp_ack, chg_ack,
        input  disp_req, disp_id, chg_req, credit, busy, coin_rej, sel_err
    );

endinterface

// File: rtl/vend_credit_acc.sv
// Credit accumulator: decodes coins, checks them against the credit ceiling,
// and holds the credit register. Subtraction never takes credit below zero.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                add_en,
    input  logic [1:0]          coin,
    input  logic                sub_en,
    input  logic [CREDIT_W-1:0] sub_val,
    input  logic                dec_en,
    output logic                coin_ok,
    output logic [CREDIT_W-1:0] credit
);

    logic [CREDIT_W:0] value;
    logic [CREDIT_W:0] sum;

    // A coin is acceptable if its code is valid and it keeps credit within the ceiling.
    always_comb begin
        value   = coin_value(coin);
        sum     = {1'b0, credit} + value;
        coin_ok = (value != '0) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    end

    // Credit register. Callers never assert more than one update at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credit <= '0;
        else if (add_en && coin_ok)
            credit <= sum[CREDIT_W-1:0];
        else if (sub_en && (sub_val <= credit))
            credit <= credit - sub_val;
        else if (dec_en && (credit != '0))
            credit <= credit - 1'b1;
    end

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller. It takes coins, dispenses a product, and returns
// change one 5Rs coin at a time.
// Optional build macro VEND_TIMEOUT_EN: idle credit is refunded automatically
// after TIMEOUT_CYC cycles without a coin or a selection.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0      = 3,
    parameter int PRICE1      = 4,
    parameter int PRICE2      = 5,
    parameter int PRICE3      = 6,
    parameter int MAX_CREDIT  = 12,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    vend_if.slave bus
);

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return CREDIT_W'(PRICE0);
            2'd1:    return CREDIT_W'(PRICE1);
            2'd2:    return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    vend_state_e         state_q, state_n;
    logic                disp_req_q, disp_req_n;
    logic [1:0]          disp_id_q, disp_id_n;
    logic                chg_req_q, chg_req_n;
    logic                busy_q, busy_n;
    logic                coin_rej_q, coin_rej_n;
    logic                sel_err_q, sel_err_n;
    logic                add_en, sub_en, dec_en;
    logic                coin_ok;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] remain;
    logic                timeout_hit;

    vend_credit_acc #(.MAX_CREDIT(MAX_CREDIT)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .add_en  (add_en),
        .coin    (bus.coin),
        .sub_en  (sub_en),
        .sub_val (price_of(disp_id_q)),
        .dec_en  (dec_en),
        .coin_ok (coin_ok),
        .credit  (credit)
    );

    assign remain = credit - price_of(disp_id_q);

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             idle_wait;

    // An idle cycle with credit and no customer activity adds to the timeout count.
    assign idle_wait   = (state_q == ST_IDLE) && (credit != '0) &&
                         !bus.cancel && !bus.sel_valid && !bus.coin_valid;
    assign timeout_hit = idle_wait && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Timeout counter. It clears on any activity, when credit leaves IDLE, or when it fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (!idle_wait || timeout_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    // Without the timeout, credit is held indefinitely and this never fires.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            disp_req_q <= 1'b0;
            disp_id_q  <= 2'd0;
            chg_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            coin_rej_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            disp_req_q <= disp_req_n;
            disp_id_q  <= disp_id_n;
            chg_req_q  <= chg_req_n;
            busy_q     <= busy_n;
            coin_rej_q <= coin_rej_n;
            sel_err_q  <= sel_err_n;
        end
    end

    // Next state, next outputs and credit commands. In IDLE the priority is
    // cancel, then select, then coin. A coin that loses arbitration is rejected.
    always_comb begin
        state_n    = state_q;
        disp_req_n = disp_req_q;
        disp_id_n  = disp_id_q;
        chg_req_n  = chg_req_q;
        coin_rej_n = 1'b0;
        sel_err_n  = 1'b0;
        add_en     = 1'b0;
        sub_en     = 1'b0;
        dec_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cancel) begin
                    coin_rej_n = bus.coin_valid;
                    if (credit != '0) begin
                        state_n   = ST_CHANGE;
                        chg_req_n = 1'b1;
                    end
                end else if (bus.sel_valid) begin
                    coin_rej_n = bus.coin_valid;
                    if (credit >= price_of(bus.sel)) begin
                        state_n    = ST_DISPENSE;
                        disp_req_n = 1'b1;
                        disp_id_n  = bus.sel;
                    end else begin
                        sel_err_n = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    add_en     = 1'b1;
                    coin_rej_n = !coin_ok;
                end else if (timeout_hit) begin
                    state_n   = ST_CHANGE;
                    chg_req_n = 1'b1;
                end
            end
            ST_DISPENSE: begin
                coin_rej_n = bus.coin_valid;
                if (bus.disp_ack) begin
                    sub_en     = 1'b1;
                    disp_req_n = 1'b0;
                    if (remain != '0) begin
                        state_n   = ST_CHANGE;
                        chg_req_n = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                coin_rej_n = bus.coin_valid;
                if (credit == '0) begin
                    state_n   = ST_IDLE;
                    chg_req_n = 1'b0;
                end else if (bus.chg_ack) begin
                    dec_en = 1'b1;
                    if (credit == CREDIT_W'(1)) begin
                        state_n   = ST_IDLE;
                        chg_req_n = 1'b0;
                    end
                end
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    assign bus.disp_req = disp_req_q;
    assign bus.disp_id  = disp_id_q;
    assign bus.chg_req  = chg_req_q;
    assign bus.credit   = credit;
    assign bus.busy     = busy_q;
    assign bus.coin_rej = coin_rej_q;
    assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_vend_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vend_if bus();

    vend_controller #(.TIMEOUT_CYC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int price [4] = '{3, 4, 5, 6};

    // Model state: mode 0 = waiting, 1 = vending, 2 = refunding.
    int m_credit, m_mode, m_id, m_rej, m_err, m_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.coin_valid = 1'b0; bus.coin = 2'b00;
        bus.sel_valid  = 1'b0; bus.sel  = 2'b00;
        bus.cancel     = 1'b0;
        bus.disp_ack   = 1'b0; bus.chg_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic coin_in(input logic [1:0] c);
        bus.coin_valid = 1'b1;
        bus.coin       = c;
        tick();
        bus.coin_valid = 1'b0;
        bus.coin       = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        if ({bus.disp_req, bus.disp_id, bus.chg_req, bus.busy, bus.coin_rej, bus.sel_err} !== 7'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 0", {bus.disp_req, bus.disp_id, bus.chg_req, bus.busy, bus.coin_rej, bus.sel_err});
        end
        total++;
        if (bus.credit !== 4'd0) begin bad++; $display("FAIL reset_credit: got %0d want 0", bus.credit); end
        total++;
        rst = 1'b0;
        tick();
    endtask

    // 10Rs + 5Rs, select product 0, motor acks on the third cycle.
    task automatic test_dispense_exact();
        int hi;
        do_reset();
        coin_in(2'b10);
        coin_in(2'b01);
        if (bus.credit !== 4'd3) begin bad++; $display("FAIL exact_credit: got %0d want 3", bus.credit); end
        total++;
        bus.sel_valid = 1'b1; bus.sel = 2'd0;
        tick();
        bus.sel_valid = 1'b0;
        if (bus.disp_req !== 1'b1 || bus.disp_id !== 2'd0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL exact_disp_start: got req=%b id=%0d busy=%b want 1 0 1", bus.disp_req, bus.disp_id, bus.busy);
        end
        total++;
        hi = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.disp_req === 1'b1 && bus.disp_id === 2'd0) hi++;
        end
        if (hi != 3) begin bad++; $display("FAIL exact_disp_hold: got %0d cycles want 3", hi); end
        total++;
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        if (bus.disp_req !== 1'b0 || bus.credit !== 4'd0 || bus.busy !== 1'b0 || bus.chg_req !== 1'b0) begin
            bad++; $display("FAIL exact_done: got req=%b credit=%0d busy=%b chg=%b want 0 0 0 0", bus.disp_req, bus.credit, bus.busy, bus.chg_req);
        end
        total++;
        tick();
        if (bus.chg_req !== 1'b0) begin bad++; $display("FAIL exact_no_change: got %b want 0", bus.chg_req); end
        total++;
    endtask

    // 20Rs + 10Rs, product 1 (price 4): two coins of change come back.
    task automatic test_change();
        do_reset();
        coin_in(2'b11);
        coin_in(2'b10);
        if (bus.credit !== 4'd6) begin bad++; $display("FAIL change_credit: got %0d want 6", bus.credit); end
        total++;
        bus.sel_valid = 1'b1; bus.sel = 2'd1;
        tick();
        bus.sel_valid = 1'b0;
        if (bus.disp_req !== 1'b1 || bus.disp_id !== 2'd1) begin
            bad++; $display("FAIL change_disp: got req=%b id=%0d want 1 1", bus.disp_req, bus.disp_id);
        end
        total++;
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        if (bus.credit !== 4'd2 || bus.chg_req !== 1'b1 || bus.disp_req !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL change_enter: got credit=%0d chg=%b disp=%b busy=%b want 2 1 0 1", bus.credit, bus.chg_req, bus.disp_req, bus.busy);
        end
        total++;
        bus.chg_ack = 1'b1;
        tick();
        if (bus.credit !== 4'd1 || bus.chg_req !== 1'b1) begin
            bad++; $display("FAIL change_first: got credit=%0d chg=%b want 1 1", bus.credit, bus.chg_req);
        end
        total++;
        tick();
        bus.chg_ack = 1'b0;
        if (bus.credit !== 4'd0 || bus.chg_req !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL change_done: got credit=%0d chg=%b busy=%b want 0 0 0", bus.credit, bus.chg_req, bus.busy);
        end
        total++;
    endtask

    // Overflow and invalid coins are rejected; so is a coin during dispense.
    task automatic test_coin_reject();
        do_reset();
        coin_in(2'b11); coin_in(2'b11); coin_in(2'b10); coin_in(2'b01);
        if (bus.credit !== 4'd11) begin bad++; $display("FAIL rej_setup: got %0d want 11", bus.credit); end
        total++;
        coin_in(2'b10);
        if (bus.coin_rej !== 1'b1 || bus.credit !== 4'd11) begin
            bad++; $display("FAIL rej_overflow: got rej=%b credit=%0d want 1 11", bus.coin_rej, bus.credit);
        end
        total++;
        tick();
        if (bus.coin_rej !== 1'b0) begin bad++; $display("FAIL rej_pulse: got %b want 0", bus.coin_rej); end
        total++;
        coin_in(2'b00);
        if (bus.coin_rej !== 1'b1 || bus.credit !== 4'd11) begin
            bad++; $display("FAIL rej_invalid: got rej=%b credit=%0d want 1 11", bus.coin_rej, bus.credit);
        end
        total++;
        bus.sel_valid = 1'b1; bus.sel = 2'd3;
        tick();
        bus.sel_valid = 1'b0;
        coin_in(2'b01);
        if (bus.coin_rej !== 1'b1 || bus.credit !== 4'd11 || bus.disp_req !== 1'b1) begin
            bad++; $display("FAIL rej_in_dispense: got rej=%b credit=%0d disp=%b want 1 11 1", bus.coin_rej, bus.credit, bus.disp_req);
        end
        total++;
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        if (bus.credit !== 4'd5 || bus.chg_req !== 1'b1) begin
            bad++; $display("FAIL rej_remainder: got credit=%0d chg=%b want 5 1", bus.credit, bus.chg_req);
        end
        total++;
        bus.chg_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.chg_ack = 1'b0;
        if (bus.credit !== 4'd0 || bus.chg_req !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rej_drain: got credit=%0d chg=%b busy=%b want 0 0 0", bus.credit, bus.chg_req, bus.busy);
        end
        total++;
    endtask

    // Insufficient credit flags sel_err. Cancel beats a same-cycle select.
    task automatic test_sel_err();
        do_reset();
        coin_in(2'b10);
        bus.sel_valid = 1'b1; bus.sel = 2'd3;
        tick();
        bus.sel_valid = 1'b0;
        if (bus.sel_err !== 1'b1 || bus.busy !== 1'b0 || bus.disp_req !== 1'b0 || bus.credit !== 4'd2) begin
            bad++; $display("FAIL selerr_pulse: got err=%b busy=%b disp=%b credit=%0d want 1 0 0 2", bus.sel_err, bus.busy, bus.disp_req, bus.credit);
        end
        total++;
        tick();
        if (bus.sel_err !== 1'b0) begin bad++; $display("FAIL selerr_clear: got %b want 0", bus.sel_err); end
        total++;
        coin_in(2'b01);
        bus.cancel = 1'b1; bus.sel_valid = 1'b1; bus.sel = 2'd0;
        tick();
        bus.cancel = 1'b0; bus.sel_valid = 1'b0;
        if (bus.chg_req !== 1'b1 || bus.disp_req !== 1'b0 || bus.sel_err !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL cancel_prio: got chg=%b disp=%b err=%b busy=%b want 1 0 0 1", bus.chg_req, bus.disp_req, bus.sel_err, bus.busy);
        end
        total++;
        bus.chg_ack = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.chg_ack = 1'b0;
        if (bus.credit !== 4'd0 || bus.chg_req !== 1'b0) begin
            bad++; $display("FAIL cancel_refund: got credit=%0d chg=%b want 0 0", bus.credit, bus.chg_req);
        end
        total++;
    endtask

    // Reset asserted between clock edges while dispensing clears everything at once.
    task automatic test_reset_mid();
        do_reset();
        coin_in(2'b11);
        bus.sel_valid = 1'b1; bus.sel = 2'd0;
        tick();
        bus.sel_valid = 1'b0;
        if (bus.disp_req !== 1'b1) begin bad++; $display("FAIL rstmid_setup: got %b want 1", bus.disp_req); end
        total++;
        #2 rst = 1'b1;
        #1;
        if ({bus.disp_req, bus.disp_id, bus.chg_req, bus.busy, bus.coin_rej, bus.sel_err, bus.credit} !== 11'b0) begin
            bad++; $display("FAIL rstmid_async: got %b want 0", {bus.disp_req, bus.disp_id, bus.chg_req, bus.busy, bus.coin_rej, bus.sel_err, bus.credit});
        end
        total++;
        tick();
        rst = 1'b0;
        tick();
        if (bus.credit !== 4'd0 || bus.chg_req !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_refund: got credit=%0d chg=%b busy=%b want 0 0 0", bus.credit, bus.chg_req, bus.busy);
        end
        total++;
    endtask

    task automatic test_timeout();
        do_reset();
        coin_in(2'b10);
`ifdef VEND_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7 && bus.chg_req !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", bus.chg_req); end
        end
        total++;
        if (bus.chg_req !== 1'b1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL timeout_fire: got chg=%b busy=%b want 1 1", bus.chg_req, bus.busy);
        end
        total++;
        bus.chg_ack = 1'b1;
        tick(); tick();
        bus.chg_ack = 1'b0;
        if (bus.credit !== 4'd0 || bus.chg_req !== 1'b0) begin
            bad++; $display("FAIL timeout_refund: got credit=%0d chg=%b want 0 0", bus.credit, bus.chg_req);
        end
        total++;
`else
        for (int i = 0; i < 30; i++) tick();
        if (bus.credit !== 4'd2 || bus.busy !== 1'b0 || bus.chg_req !== 1'b0) begin
            bad++; $display("FAIL hold_credit: got credit=%0d busy=%b chg=%b want 2 0 0", bus.credit, bus.busy, bus.chg_req);
        end
        total++;
`endif
    endtask

    // Randomized traffic against the behavioural model.
    task automatic test_random();
        logic       cv, sv, cn, dk, ck;
        logic [1:0] c, s;
        logic [10:0] exp, got;
        int v, rej, err, idle_tick;
        do_reset();
        m_credit = 0; m_mode = 0; m_id = 0; m_rej = 0; m_err = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            cv = ($urandom_range(0, 99) < 30);
            sv = ($urandom_range(0, 99) < 10);
            cn = ($urandom_range(0, 99) < 3);
            dk = ($urandom_range(0, 99) < 40);
            ck = ($urandom_range(0, 99) < 50);
            c  = 2'($urandom_range(0, 3));
            s  = 2'($urandom_range(0, 3));
            bus.coin_valid = cv; bus.coin = c; bus.sel_valid = sv; bus.sel = s;
            bus.cancel = cn; bus.disp_ack = dk; bus.chg_ack = ck;
            rej = 0; err = 0; idle_tick = 0;
            if (m_mode == 0) begin
                if (cn) begin
                    if (m_credit > 0) m_mode = 2;
                    rej = cv;
                end else if (sv) begin
                    if (m_credit >= price[s]) begin m_mode = 1; m_id = s; end
                    else err = 1;
                    rej = cv;
                end else if (cv) begin
                    v = (c == 2'b11) ? 4 : int'(c);
                    if (v != 0 && m_credit + v <= 12) m_credit += v;
                    else rej = 1;
                end else if (m_credit > 0) begin
                    idle_tick = 1;
                end
            end else if (m_mode == 1) begin
                rej = cv;
                if (dk) begin
                    m_credit -= price[m_id];
                    m_mode = (m_credit > 0) ? 2 : 0;
                end
            end else begin
                rej = cv;
                if (ck) begin
                    m_credit--;
                    if (m_credit == 0) m_mode = 0;
                end
            end
`ifdef VEND_TIMEOUT_EN
            if (idle_tick != 0) begin
                m_cnt++;
                if (m_cnt == 8) begin m_mode = 2; m_cnt = 0; end
            end else begin
                m_cnt = 0;
            end
`endif
            m_rej = rej; m_err = err;
            tick();
            exp = {m_mode != 0, m_mode == 1, 2'(m_id), m_mode == 2, 4'(m_credit), m_rej != 0, m_err != 0};
            got = {bus.busy, bus.disp_req, bus.disp_id, bus.chg_req, bus.credit, bus.coin_rej, bus.sel_err};
            if (got !== exp) begin
                bad++; $display("FAIL random_cycle%0d: got %b want %b", n, got, exp);
            end
            total++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_dispense_exact();
        test_change();
        test_coin_reject();
        test_sel_err();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
